motor_cmd_dispatcher: RTL

Sequences the per-axis step/dir channels from the host UART byte stream.
- Parses 5-byte command frames from the async receiver.
- Holds one pending command per channel and loads it into the channel when that channel is idle.
- Tracks acceptance through the channel's activeMode and publishes per-channel pending flags for the status reporter.
- Sits between async_receiver and the array of motorCtrlSimple_v2 instances.

---
 rtl/motor_cmd_dispatcher.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_dispatcher.sv
// Turns the host UART byte stream into per-channel step/divider commands with one pending slot per channel.
// Optional DISPATCH_STATS_EN adds drop_cnt, a saturating count of dropped or failed commands.
module motor_cmd_dispatcher #(
  parameter int NUM_CH      = 10,
  parameter int DIV_W       = 15,
  parameter int STEPS_W     = 13,
  parameter int GAP_TIMEOUT = 24000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                      CLK_SE_AR,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic [NUM_CH-1:0]         ch_active,
  output logic [NUM_CH*DIV_W-1:0]   ch_divider,
  output logic [NUM_CH*STEPS_W-1:0] ch_steps,
  output logic [NUM_CH-1:0]         ch_load,
  output logic [NUM_CH-1:0]         pending,
  output logic                      frame_err,
  output logic                      ovf,
  output logic                      bad_ch,
  output logic                      ack_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure, so every byte is consumed.
  // ch_load[i] fires once while the channel is idle; ch_active[i] rising is the channel's acceptance.

  localparam int PAY_W = DIV_W + STEPS_W - 8;
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {P_HDR, P_PAY} parse_t;
  typedef enum logic [1:0] {S_EMPTY, S_PENDING, S_ISSUED} slot_t;

  parse_t             p_state_q, p_state_d;
  logic [3:0]         ch_q;
  logic [1:0]         byte_cnt_q;
  logic [PAY_W-1:0]   word_q;
  logic [GAP_W-1:0]   gap_q;
  logic               hdr_ok;
  logic               commit;
  logic               gap_hit;

  logic [PAY_W+7:0]   frame_w;
  logic [DIV_W-1:0]   new_div;
  logic [STEPS_W-1:0] new_steps;
  logic               ch_bad;
  logic               slot_busy;
  logic               commit_bad;
  logic               commit_ovf;
  logic               commit_store;

  slot_t              slot_q [NUM_CH];
  slot_t              slot_d [NUM_CH];
  logic [DIV_W-1:0]   div_q [NUM_CH];
  logic [STEPS_W-1:0] steps_q [NUM_CH];
  logic [ACK_W-1:0]   ack_cnt_q [NUM_CH];
  logic [NUM_CH-1:0]  act_q;
  logic [NUM_CH-1:0]  store_hit;
  logic [NUM_CH-1:0]  load_w;
  logic [NUM_CH-1:0]  ack_to;

  // Parser next-state: header resync, payload collection, inter-byte gap abort.
  always_comb begin
    p_state_d = p_state_q;
    hdr_ok    = 1'b0;
    commit    = 1'b0;
    gap_hit   = 1'b0;
    case (p_state_q)
      P_HDR: begin
        if (rx_valid && rx_data[7:4] == 4'h0) begin
          hdr_ok    = 1'b1;
          p_state_d = P_PAY;
        end
      end
      P_PAY: begin
        if (rx_valid) begin
          if (byte_cnt_q == 2'd3) begin
            commit    = 1'b1;
            p_state_d = P_HDR;
          end
        end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
          gap_hit   = 1'b1;
          p_state_d = P_HDR;
        end
      end
      default: p_state_d = P_HDR;
    endcase
  end

  // word_q keeps only W[31-8:4]; the reserved low nibble of b1 is never stored.
  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q  <= P_HDR;
      ch_q       <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      gap_q      <= '0;
    end else begin
      p_state_q <= p_state_d;
      if (hdr_ok) begin
        ch_q       <= rx_data[3:0];
        byte_cnt_q <= '0;
      end else if (p_state_q == P_PAY && rx_valid) begin
        word_q     <= {rx_data, word_q[PAY_W-1:8]};
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (rx_valid || p_state_q != P_PAY || gap_hit) gap_q <= '0;
      else                                          gap_q <= gap_q + 1'b1;
    end
  end

  assign frame_w   = {rx_data, word_q};
  assign new_div   = frame_w[DIV_W-1:0];
  assign new_steps = frame_w[DIV_W +: STEPS_W];

  // Occupancy is judged on the registered slot state, so a slot freeing this cycle still rejects.
  always_comb begin
    slot_busy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == 4'(i) && slot_q[i] != S_EMPTY) slot_busy = 1'b1;
    end
  end

  assign ch_bad       = ({1'b0, ch_q} >= 5'(NUM_CH));
  assign commit_bad   = commit & ch_bad;
  assign commit_ovf   = commit & ~ch_bad & slot_busy;
  assign commit_store = commit & ~ch_bad & ~slot_busy & (new_steps != '0);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      slot_d[i]    = slot_q[i];
      load_w[i]    = 1'b0;
      ack_to[i]    = 1'b0;
      store_hit[i] = commit_store && (ch_q == 4'(i));
      case (slot_q[i])
        S_EMPTY: begin
          if (store_hit[i]) slot_d[i] = S_PENDING;
        end
        S_PENDING: begin
          if (!ch_active[i]) begin
            load_w[i] = 1'b1;
            slot_d[i] = S_ISSUED;
          end
        end
        S_ISSUED: begin
          if (ch_active[i] && !act_q[i]) begin
            slot_d[i] = S_EMPTY;
          end else if (ack_cnt_q[i] == ACK_W'(ACK_TIMEOUT - 1)) begin
            ack_to[i] = 1'b1;
            slot_d[i] = S_EMPTY;
          end
        end
        default: slot_d[i] = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        slot_q[i]    <= S_EMPTY;
        div_q[i]     <= '0;
        steps_q[i]   <= '0;
        ack_cnt_q[i] <= '0;
      end
      act_q   <= '0;
      pending <= '0;
    end else begin
      act_q <= ch_active;
      for (int i = 0; i < NUM_CH; i++) begin
        slot_q[i]  <= slot_d[i];
        pending[i] <= (slot_q[i] != S_EMPTY);
        if (store_hit[i]) begin
          div_q[i]   <= new_div;
          steps_q[i] <= new_steps;
        end
        if (load_w[i])                  ack_cnt_q[i] <= '0;
        else if (slot_q[i] == S_ISSUED) ack_cnt_q[i] <= ack_cnt_q[i] + 1'b1;
      end
    end
  end

  // The divider keeps its last value once a slot empties; only the step count is forced to zero.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_divider[g*DIV_W +: DIV_W]   = div_q[g];
    assign ch_steps[g*STEPS_W +: STEPS_W] = (slot_q[g] == S_EMPTY) ? '0 : steps_q[g];
  end

  assign ch_load = load_w;

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      ovf       <= 1'b0;
      bad_ch    <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      frame_err <= gap_hit;
      ovf       <= commit_ovf;
      bad_ch    <= commit_bad;
      ack_err   <= |ack_to;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic        stats_clr;
  logic [4:0]  ev_cnt;
  logic [16:0] drop_sum;

  assign stats_clr = (p_state_q == P_HDR) && rx_valid && (rx_data == 8'hF0);

  // Every event counts on its own, including several channels timing out together.
  always_comb begin
    ev_cnt = 5'(gap_hit) + 5'(commit_ovf) + 5'(commit_bad);
    for (int i = 0; i < NUM_CH; i++) ev_cnt = ev_cnt + 5'(ack_to[i]);
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ev_cnt);

  always_ff @(posedge CLK_SE_AR or negedge rst_n) begin
    if (!rst_n)            drop_cnt <= '0;
    else if (stats_clr)    drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                   drop_cnt <= drop_sum[15:0];
  end
`endif

endmodule
